// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blink_pkg
//  Purpose  : Shared command encodings, sequencer states and defaults for the
//             LED blink scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package blink_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_START  = 2'b01,
    OP_STOP   = 2'b10,
    OP_SETLEN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int c_default_tick_bit = 12;

endpackage
`default_nettype wire

// File: rtl/blink_table.sv
`default_nettype none
// ============================================================================
//  Module   : blink_table
//  Purpose  : Single-port pattern table, synchronous write, registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module blink_table
  import blink_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Contents are deliberately left unreset; the host must program them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/blink_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : blink_scheduler
//  Purpose  : Steps through a host-programmed table of LED patterns, each held
//             for a programmable number of ticks of the shared counter.
//  Revision : 1.0 - initial release
// ============================================================================
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int TICK_BIT = c_default_tick_bit,
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       current_count,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [8+DUR_W-1:0] cmd_data,
  output logic [7:0]        led_out,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              wrap_pulse
);

  localparam int c_ew = 8 + DUR_W;
  localparam logic [4:0]     c_depth     = 5'(DEPTH);
  localparam logic [DUR_W:0] c_dwell_max = {1'b1, {DUR_W{1'b0}}};
  localparam logic [DUR_W:0] c_dwell_one = {{DUR_W{1'b0}}, 1'b1};

  state_e              r_state;
  logic                r_prev_bit;
  logic [4:0]          r_len;
  logic [AW-1:0]       r_step;
  logic [AW-1:0]       r_step_idx;
  logic [7:0]          r_led;
  logic [DUR_W:0]      r_dwell;
  logic                r_wrap;
  logic                r_load;
  logic                r_tick_pend;

  logic                w_tick;
  logic                w_evt;
  logic                w_accept;
  logic                w_we;
  logic                w_start;
  logic                w_stop;
  logic                w_setlen;
  logic [4:0]          w_new_len;
  logic                w_last;
  logic [AW-1:0]       w_tbl_addr;
  logic [c_ew-1:0]     w_tbl_rdata;
  logic [DUR_W-1:0]    w_field;
  logic [DUR_W:0]      w_dwell_ld;
  logic                w_unused;

  assign w_unused  = ^current_count;

  assign w_tick    = current_count[TICK_BIT] & ~r_prev_bit;
  assign w_evt     = w_tick | r_tick_pend;

  assign cmd_ready = (r_state != ST_FETCH);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_we      = w_accept & (cmd_op == OP_WRITE);
  assign w_start   = w_accept & (cmd_op == OP_START);
  assign w_stop    = w_accept & (cmd_op == OP_STOP);
  assign w_setlen  = w_accept & (cmd_op == OP_SETLEN);

  assign w_new_len = (cmd_data[4:0] > c_depth) ? c_depth : cmd_data[4:0];
  assign w_last    = (5'(r_step) == (r_len - 5'd1));

  // The sequencer owns the single table port during FETCH; hosts are stalled.
  assign w_tbl_addr = (r_state == ST_FETCH) ? r_step : cmd_addr;

  assign w_field    = w_tbl_rdata[c_ew-1:8];
  assign w_dwell_ld = (w_field == '0) ? c_dwell_max : {1'b0, w_field};

  blink_table #(
    .DEPTH (DEPTH),
    .WIDTH (c_ew)
  ) u_table (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_tbl_addr),
    .i_wdata (cmd_data),
    .o_rdata (w_tbl_rdata)
  );

  // r_load marks the cycle after FETCH, when the registered table read is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prev_bit  <= 1'b0;
      r_len       <= '0;
      r_step      <= '0;
      r_step_idx  <= '0;
      r_led       <= '0;
      r_dwell     <= '0;
      r_wrap      <= 1'b0;
      r_load      <= 1'b0;
      r_tick_pend <= 1'b0;
    end else begin
      r_prev_bit <= current_count[TICK_BIT];
      r_wrap     <= 1'b0;
      if (w_setlen) begin
        r_len <= w_new_len;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start && (r_len != '0)) begin
            r_state <= ST_FETCH;
            r_step  <= '0;
          end
        end
        ST_FETCH: begin
          r_state <= ST_RUN;
          r_load  <= 1'b1;
          if (w_tick) begin
            r_tick_pend <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_stop || (w_setlen && (w_new_len == '0))) begin
            r_state     <= ST_IDLE;
            r_led       <= '0;
            r_step      <= '0;
            r_step_idx  <= '0;
            r_dwell     <= '0;
            r_load      <= 1'b0;
            r_tick_pend <= 1'b0;
          end else if (w_start) begin
            r_state <= ST_FETCH;
            r_step  <= '0;
            r_load  <= 1'b0;
          end else if (w_setlen && (w_new_len <= 5'(r_step))) begin
            r_state <= ST_FETCH;
            r_step  <= '0;
            r_load  <= 1'b0;
            r_wrap  <= 1'b1;
          end else if (r_load) begin
            r_led      <= w_tbl_rdata[7:0];
            r_step_idx <= r_step;
            r_dwell    <= w_dwell_ld;
            r_load     <= 1'b0;
            if (w_tick) begin
              r_tick_pend <= 1'b1;
            end
          end else if (w_evt) begin
            r_tick_pend <= 1'b0;
            r_dwell     <= r_dwell - c_dwell_one;
            if (r_dwell == c_dwell_one) begin
              r_state <= ST_FETCH;
              if (w_last) begin
                r_step <= '0;
                r_wrap <= 1'b1;
              end else begin
                r_step <= r_step + AW'(1);
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign led_out    = r_led;
  assign step_idx   = r_step_idx;
  assign busy       = (r_state != ST_IDLE);
  assign wrap_pulse = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_blink_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blink_scheduler
//  Purpose  : Directed, table-driven bench for blink_scheduler (TICK_BIT=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] current_count;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr;
  logic [11:0] cmd_data;
  logic [7:0]  led_out;
  logic [2:0]  step_idx;
  logic        busy;
  logic        wrap_pulse;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       tk;
    logic [7:0] led;
    logic [2:0] step;
    logic       busy;
    logic       wrap;
  } vec_t;

  vec_t vecs [11];

  blink_scheduler #(
    .TICK_BIT (2),
    .DEPTH    (8),
    .DUR_W    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .current_count (current_count),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .led_out       (led_out),
    .step_idx      (step_idx),
    .busy          (busy),
    .wrap_pulse    (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] addr, input logic [11:0] data);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && n < 20) begin
      clk1();
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    clk1();
    cmd_valid = 1'b0;
  endtask

  task automatic tick();
    current_count = 16'h0004;
    clk1();
    current_count = 16'h0000;
    clk1();
  endtask

  initial begin
    // {tick, led, step, busy, wrap}; row 0 is the edge after START is accepted.
    vecs[0]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'hA5, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h3C, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 3'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h3C, 3'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h3C, 3'd1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h3C, 3'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};

    rst           = 1'b1;
    current_count = '0;
    cmd_valid     = 1'b0;
    cmd_op        = 2'b00;
    cmd_addr      = '0;
    cmd_data      = '0;
    repeat (3) clk1();
    chk("reset_outputs", {led_out, step_idx, busy, wrap_pulse}, {8'h00, 3'd0, 1'b0, 1'b0});
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    clk1();

    // Two-step sequence with wrap.
    send(2'b00, 3'd0, 12'h1A5);
    send(2'b00, 3'd1, 12'h23C);
    send(2'b11, 3'd0, 12'h002);
    send(2'b01, 3'd0, 12'h000);
    chk("start_fetch_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 11; i++) begin
      current_count = vecs[i].tk ? 16'h0004 : 16'h0000;
      clk1();
      chk($sformatf("seq_row%0d", i), {led_out, step_idx, busy, wrap_pulse},
          {vecs[i].led, vecs[i].step, vecs[i].busy, vecs[i].wrap});
    end
    current_count = '0;

    // Asynchronous reset in the middle of RUN.
    rst = 1'b1;
    #1;
    chk("async_reset_mid_run", {led_out, step_idx, busy, wrap_pulse}, {8'h00, 3'd0, 1'b0, 1'b0});
    clk1();
    rst = 1'b0;
    clk1();

    // Dwell field 0 holds the pattern for 16 ticks.
    send(2'b00, 3'd0, 12'h011);
    send(2'b00, 3'd1, 12'h122);
    send(2'b11, 3'd0, 12'h002);
    send(2'b01, 3'd0, 12'h000);
    clk1();
    clk1();
    chk("dwell16_loaded", 32'(led_out), 32'h11);
    for (int i = 0; i < 15; i++) tick();
    chk("dwell16_after15", {led_out, busy}, {8'h11, 1'b1});
    tick();
    chk("dwell16_t16_plus1", 32'(led_out), 32'h11);
    clk1();
    chk("dwell16_t16_plus2", {led_out, step_idx}, {8'h22, 3'd1});

    // Host write held through FETCH.
    current_count = 16'h0004;
    clk1();
    current_count = 16'h0000;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_addr  = 3'd0;
    cmd_data  = 12'h377;
    chk("fetch_ready_low", 32'(cmd_ready), 32'd0);
    chk("fetch_wrap", 32'(wrap_pulse), 32'd1);
    clk1();
    chk("post_fetch_ready", 32'(cmd_ready), 32'd1);
    clk1();
    cmd_valid = 1'b0;
    chk("write_old_shown", {led_out, step_idx}, {8'h11, 3'd0});
    send(2'b01, 3'd0, 12'h000);
    chk("restart_no_wrap", {busy, wrap_pulse}, {1'b1, 1'b0});
    clk1();
    clk1();
    chk("restart_new_entry", {led_out, step_idx}, {8'h77, 3'd0});
    tick();
    tick();
    tick();
    clk1();
    chk("entry1_untouched", {led_out, step_idx}, {8'h22, 3'd1});

    // SETLEN 0 while running, then START with length 0.
    send(2'b11, 3'd0, 12'h000);
    chk("setlen0_idle", {led_out, busy}, {8'h00, 1'b0});
    send(2'b01, 3'd0, 12'h000);
    chk("start_len0_ignored", {led_out, busy}, {8'h00, 1'b0});
    clk1();
    chk("start_len0_still_idle", 32'(busy), 32'd0);

    // SETLEN 20 clamps to 8 entries.
    for (int i = 0; i < 8; i++) begin
      send(2'b00, 3'(i), {4'h1, 8'(8'h10 + i)});
    end
    send(2'b11, 3'd0, 12'h014);
    send(2'b01, 3'd0, 12'h000);
    clk1();
    clk1();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clamp_step%0d", i), {led_out, step_idx}, {8'(8'h10 + i), 3'(i)});
      current_count = 16'h0004;
      clk1();
      chk($sformatf("clamp_wrap%0d", i), 32'(wrap_pulse), (i == 7) ? 32'd1 : 32'd0);
      current_count = 16'h0000;
      clk1();
      clk1();
    end
    chk("clamp_wrapped", {led_out, step_idx}, {8'h10, 3'd0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
